pci_central_arbiter: RTL



---
 rtl/pci_arb_pkg.sv | 29 ++
 rtl/pci_central_arbiter_if.sv | 20 ++
 rtl/pci_arb_rr_pick.sv | 44 ++++
 rtl/pci_central_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// ---------------------------------------------------------------------------
// pci_arb_pkg
// Shared types and helpers for the PCI central arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, GRANTED, BUSY, CHANGE)
//   ARB_MAX_MASTERS : upper bound on REQ#/GNT# pairs supported
//   clog2()         : constant ceil(log2) used for index/counter widths
// ---------------------------------------------------------------------------
package pci_arb_pkg;

  localparam int unsigned ARB_MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    CHANGE  = 2'd3
  } arb_state_t;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_central_arbiter_if.sv
// ---------------------------------------------------------------------------
// pci_central_arbiter_if
// PCI arbitration signals shared between the agents and the central arbiter.
//   req_n   : REQ# per agent, active low      (agents -> arbiter)
//   frame_n : FRAME#                          (bus    -> arbiter)
//   irdy_n  : IRDY#                           (bus    -> arbiter)
//   gnt_n   : GNT# per agent, active low      (arbiter -> agents)
// Modports: master = agent/bus side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface pci_central_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] req_n;
  logic                   frame_n;
  logic                   irdy_n;
  logic [NUM_MASTERS-1:0] gnt_n;

  modport master (output req_n, output frame_n, output irdy_n, input gnt_n);
  modport slave  (input req_n, input frame_n, input irdy_n, output gnt_n);
endinterface

// File: rtl/pci_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// pci_arb_rr_pick
// Combinational round-robin picker. Scans last_i+1, last_i+2, ... (mod
// NUM_MASTERS) and returns the first active request, so the last owner has
// the lowest priority.
//   req_i   : active-high request vector
//   last_i  : index of the last granted agent
//   idx_o   : chosen agent index (0 when valid_o = 0)
//   valid_o : at least one request present
// ---------------------------------------------------------------------------
module pci_arb_rr_pick
  import pci_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  localparam int unsigned OW          = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OW-1:0]          last_i,
  output logic [OW-1:0]          idx_o,
  output logic                   valid_o
);

  int unsigned   j;
  logic [OW-1:0] jj;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      j = 32'(last_i) + k;
      if (j >= NUM_MASTERS) begin
        j = j - NUM_MASTERS;
      end
      jj = OW'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/pci_central_arbiter.sv
// ---------------------------------------------------------------------------
// pci_central_arbiter
// Round-robin central PCI arbiter with grant-timeout recovery and optional
// bus parking (enable with `define PCI_ARB_PARK_EN).
//   pci_clk       : PCI clock
//   pci_reset     : synchronous active-high reset
//   arb_enable    : 1 = new grants allowed
//   bus           : REQ#/FRAME#/IRDY# in, GNT# out (registered)
//   owner         : index of current/last granted agent
//   bus_idle      : registered FRAME#=1 and IRDY#=1
//   timeout_pulse : one-clock pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module pci_central_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  parameter  int unsigned GNT_TIMEOUT = 16,
  parameter  int unsigned PARK_MASTER = 0,
  localparam int unsigned OW          = clog2(NUM_MASTERS)
) (
  input  logic                        pci_clk,
  input  logic                        pci_reset,
  input  logic                        arb_enable,
  pci_central_arbiter_if.slave        bus,
  output logic [OW-1:0]               owner,
  output logic                        bus_idle,
  output logic                        timeout_pulse
);

`ifdef PCI_ARB_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  localparam int unsigned            TW       = clog2(GNT_TIMEOUT + 1);
  localparam logic [NUM_MASTERS-1:0] ONE      = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]          PARK_IDX = OW'(PARK_MASTER);
  localparam logic [NUM_MASTERS-1:0] PARK_GNT = ~(ONE << PARK_IDX);
  localparam logic [TW-1:0]          T_LAST   = TW'(GNT_TIMEOUT - 1);

  arb_state_t             state_q;
  logic [NUM_MASTERS-1:0] req_q;
  logic                   frame_q;
  logic                   irdy_q;
  logic [NUM_MASTERS-1:0] gnt_n_q;
  logic [OW-1:0]          owner_q;
  logic [TW-1:0]          tcnt_q;
  logic                   timeout_q;

  logic [NUM_MASTERS-1:0] req_act;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [OW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   others_req;
  logic                   idle_w;
  logic                   parked;

  assign req_act    = ~req_q;
  assign grant_n    = ~(ONE << pick_idx);
  assign others_req = |(req_act & ~(ONE << owner_q));
  // frame_q/irdy_q reset low so bus_idle reads 0 until the bus is sampled.
  assign idle_w     = frame_q & irdy_q;
  assign parked     = PARK_EN && (gnt_n_q == PARK_GNT);

  pci_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req_i   (req_act),
    .last_i  (owner_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge pci_clk) begin
    if (pci_reset) begin
      state_q   <= IDLE;
      req_q     <= '1;
      frame_q   <= 1'b0;
      irdy_q    <= 1'b0;
      gnt_n_q   <= '1;
      owner_q   <= OW'(NUM_MASTERS - 1);
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      req_q     <= bus.req_n;
      frame_q   <= bus.frame_n;
      irdy_q    <= bus.irdy_n;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_enable && pick_valid) begin
            // Leaving a park for another agent still needs a turnaround clock.
            if (parked && (pick_idx != PARK_IDX)) begin
              gnt_n_q <= '1;
              state_q <= CHANGE;
            end else begin
              owner_q <= pick_idx;
              gnt_n_q <= grant_n;
              tcnt_q  <= '0;
              state_q <= GRANTED;
            end
          end else if (arb_enable && PARK_EN) begin
            owner_q <= PARK_IDX;
            gnt_n_q <= PARK_GNT;
          end else begin
            gnt_n_q <= '1;
          end
        end
        GRANTED: begin
          if (!arb_enable) begin
            gnt_n_q <= '1;
            state_q <= CHANGE;
          end else if (!frame_q) begin
            state_q <= BUSY;
          end else if (idle_w && (tcnt_q == T_LAST)) begin
            // Timeout wins over a simultaneous REQ# release: one transition.
            timeout_q <= 1'b1;
            gnt_n_q   <= '1;
            state_q   <= CHANGE;
          end else if (req_q[owner_q]) begin
            gnt_n_q <= '1;
            state_q <= CHANGE;
          end else if (idle_w) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        BUSY: begin
          if (!arb_enable || others_req) begin
            gnt_n_q <= '1;
            state_q <= CHANGE;
          end else if (idle_w) begin
            gnt_n_q <= '1;
            state_q <= IDLE;
          end
        end
        CHANGE: begin
          // The turnaround clock also performs the IDLE evaluation so only a
          // single all-high GNT# clock separates two owners.
          if (arb_enable && pick_valid) begin
            owner_q <= pick_idx;
            gnt_n_q <= grant_n;
            tcnt_q  <= '0;
            state_q <= GRANTED;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_n_q <= '1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_n     = gnt_n_q;
  assign owner         = owner_q;
  assign bus_idle      = idle_w;
  assign timeout_pulse = timeout_q;

endmodule
